// File: rtl/elevator_ctrl_multi.sv
// Multi-floor elevator controller.
// Latches per-floor call requests, moves the car one floor per TRAVEL_CYCLES
// and times the door internally. Service follows SCAN order: keep going in
// the current direction while requests lie ahead, then reverse.
//
// Handshake note: there is no valid/ready pair here. req is sampled on every
// rising edge and OR-ed into pending; a request is "accepted" the cycle it is
// seen and is retired only when the car opens its door at that floor.
module elevator_ctrl_multi #(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  output logic                  motor_up,
  output logic                  motor_down,
  output logic                  door_open,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [1:0]            current_state,
  output logic                  dir_up
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_MOVE_UP   = 2'b01,
    ST_MOVE_DOWN = 2'b10,
    ST_DOOR_OPEN = 2'b11
  } state_t;

  localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TCW-1:0] TRAVEL_LAST = TCW'(TRAVEL_CYCLES - 1);
  localparam logic [DCW-1:0] DOOR_LAST   = DCW'(DOOR_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic                    dir_up_q, dir_up_d;
  logic [TCW-1:0]          travel_cnt_q, travel_cnt_d;
  logic [DCW-1:0]          door_cnt_q, door_cnt_d;

  logic [NUM_FLOORS-1:0]   clr;
  logic [NUM_FLOORS-1:0]   merged;
  logic [FLOOR_W-1:0]      step_floor;
  logic                    here, above, below;
  logic                    arr_here, arr_above, arr_below;

  // State, position, request and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      floor_q      <= '0;
      pending_q    <= '0;
      dir_up_q     <= 1'b1;
      travel_cnt_q <= '0;
      door_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      pending_q    <= pending_d;
      dir_up_q     <= dir_up_d;
      travel_cnt_q <= travel_cnt_d;
      door_cnt_q   <= door_cnt_d;
    end
  end

  // Request flags around the car now, and around the floor it is about to reach.
  // The arrival flags use pending|req so a call landing on the arrival edge is honoured.
  always_comb begin
    merged     = pending_q | req;
    step_floor = (state_q == ST_MOVE_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    here       = pending_q[floor_q];
    arr_here   = merged[step_floor];
    above      = 1'b0;
    below      = 1'b0;
    arr_above  = 1'b0;
    arr_below  = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i]) begin
        if (i > int'(floor_q)) above = 1'b1;
        if (i < int'(floor_q)) below = 1'b1;
      end
      if (merged[i]) begin
        if (i > int'(step_floor)) arr_above = 1'b1;
        if (i < int'(step_floor)) arr_below = 1'b1;
      end
    end
  end

  // Next-state logic: SCAN scheduling, floor stepping, door timing and request clear.
  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    dir_up_d     = dir_up_q;
    travel_cnt_d = '0;
    door_cnt_d   = '0;
    clr          = '0;
    case (state_q)
      ST_IDLE: begin
        if (here) begin
          state_d      = ST_DOOR_OPEN;
          clr[floor_q] = 1'b1;
        end else if (above && (dir_up_q || !below)) begin
          state_d  = ST_MOVE_UP;
          dir_up_d = 1'b1;
        end else if (below) begin
          state_d  = ST_MOVE_DOWN;
          dir_up_d = 1'b0;
        end
      end
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (travel_cnt_q == TRAVEL_LAST) begin
          // Arrival edge: the step completes and the new floor decides what follows.
          floor_d = step_floor;
          if (arr_here) begin
            state_d         = ST_DOOR_OPEN;
            clr[step_floor] = 1'b1;
          end else if ((state_q == ST_MOVE_UP) ? arr_above : arr_below) begin
            state_d = state_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          travel_cnt_d = travel_cnt_q + TCW'(1);
        end
      end
      ST_DOOR_OPEN: begin
        // Calls for the floor the door is open at are absorbed and hold the door open.
        clr[floor_q] = 1'b1;
        if (req[floor_q]) begin
          door_cnt_d = '0;
        end else if (door_cnt_q == DOOR_LAST) begin
          state_d = ST_IDLE;
        end else begin
          door_cnt_d = door_cnt_q + DCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pending_d = (pending_q | req) & ~clr;
  end

  // Moore output decode from the state register only.
  always_comb begin
    motor_up      = (state_q == ST_MOVE_UP);
    motor_down    = (state_q == ST_MOVE_DOWN);
    door_open     = (state_q == ST_DOOR_OPEN);
    current_state = state_q;
    current_floor = floor_q;
    pending       = pending_q;
    dir_up        = dir_up_q;
  end

endmodule

// File: doc/elevator_ctrl_multi.md
Name: elevator_ctrl_multi

Overview:
Parametrised multi-floor elevator controller and successor to the two-floor-agnostic UP/DOWN/EQ/T state machine. It latches per-floor call requests and tracks the car position with an internal travel timer. It schedules service in SCAN order: finish the current direction, then reverse. It times the door internally, so no external EQ/T inputs are needed.

Parameters:
NUM_FLOORS, 8, number of floors served; legal values are 2 or more.
FLOOR_W, 3, width of the floor index; must equal clog2(NUM_FLOORS).
TRAVEL_CYCLES, 16, clock cycles needed to move one floor; 1 or more.
DOOR_CYCLES, 32, clock cycles the door stays open; 1 or more.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  NUM_FLOORS  call request per floor; level or pulse; OR-ed into pending every cycle
motor_up  out  1  car moving up
motor_down  out  1  car moving down
door_open  out  1  door open
current_floor  out  FLOOR_W  car position, 0 = bottom floor
pending  out  NUM_FLOORS  latched, unserved requests
current_state  out  2  FSM state: IDLE=00, MOVE_UP=01, MOVE_DOWN=10, DOOR_OPEN=11
dir_up  out  1  scan-direction preference

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on the port reset. While reset is high:
  - current_state=IDLE, current_floor=0, pending=0, dir_up=1.
  - Travel counter and door counter are 0.
  - motor_up, motor_down and door_open are all 0.
- Outputs are Moore-decoded from current_state only:
  - MOVE_UP drives motor_up=1.
  - MOVE_DOWN drives motor_down=1.
  - DOOR_OPEN drives door_open=1.
  - All other cases drive 0. At most one output is ever high.
- Request latching: each edge, pending <= (pending | req) & ~clr. clr is the one-hot clear of current_floor described below. If set and clear hit the same bit in the same cycle, clear wins. A req pulse at edge t is visible in pending from t+1.
- Derived flags, combinational from pending and current_floor: here (bit at current_floor), above (any higher bit), below (any lower bit).
- IDLE, in priority order:
  - here: go to DOOR_OPEN and clear the bit.
  - above and (dir_up or !below): go to MOVE_UP and set dir_up=1.
  - below: go to MOVE_DOWN and set dir_up=0.
  - otherwise: stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - The travel counter counts 0..TRAVEL_CYCLES-1.
  - On the edge where it equals TRAVEL_CYCLES-1, current_floor steps by ±1 and the counter returns to 0.
  - On that same edge, the new floor's bit decides the next state. If that bit is set (including a bit set by req that cycle), go to DOOR_OPEN and clear it.
  - Otherwise continue in the same direction if requests exist further ahead. If none exist, go to IDLE.
  - One floor step therefore takes exactly TRAVEL_CYCLES cycles with the motor asserted.
- Floor limits: current_floor never exceeds NUM_FLOORS-1 and never goes below 0. The FSM must never enter MOVE_UP at the top floor or MOVE_DOWN at floor 0.
- DOOR_OPEN:
  - The door counter counts 0..DOOR_CYCLES-1. At DOOR_CYCLES-1, go to IDLE.
  - A request for current_floor during DOOR_OPEN is cleared immediately (it never appears in pending). It restarts the door counter at 0, which re-opens the door.
  - Requests for other floors accumulate in pending and are served from IDLE.
- Counters reset to 0 on every state change.
- Mid-operation reset aborts any motion immediately, with no completion of the floor step. The car is re-homed to floor 0 logically.

Test Plan:
Use NUM_FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=6.
1. Assert reset, then release it -> all outputs 0, current_floor=0, current_state=00, dir_up=1, pending=0; idle with req=0 for 20 cycles -> no change.
2. From floor 0, pulse req=8'b0010_0000 -> pending bit 5 set next cycle; motor_up high 20 cycles; current_floor 5; door_open high 6 cycles; pending=0; back to IDLE.
3. Car moving up from 2 toward 6; pulse req bit 4 during the 2→3 travel -> stop at 4 (door 6 cycles), then IDLE→MOVE_UP to 6 and open there.
4. Idle at floor 4, dir_up=1; pulse bits 1 and 6 in the same cycle -> serve 6 first (8 cycles up), then reverse to 1 (20 cycles down, dir_up=0).
5. Door open at floor 3; pulse req bit 3 on door cycle 4 -> bit 3 never set in pending; door_open high 4+6=10 consecutive cycles.
6. Assert reset asynchronously during MOVE_UP with pending=8'hC0 -> outputs drop the same cycle without waiting for clk; current_floor=0, pending=0, state IDLE after release.
